// File: rtl/bp_mc_out_arbiter.sv
// bp_mc_out_arbiter
//   Shares the single manycore endpoint out-request port between several
//   BlackParrot-side packet sources. A round-robin arbiter picks one valid
//   requester per cycle. It grants only when all of the following hold:
//   the one-entry output register is free, an endpoint credit is available,
//   and no fence is waiting for outstanding requests to return.
//   The granted packet sits in the output register until the endpoint
//   accepts it.
//
// Ports
//   clk_i            clock
//   reset_n_i        asynchronous active-low reset
//   req_v_i          per-requester packet valid
//   req_packet_i     packets, requester i at [i*packet_width_p +: packet_width_p]
//   req_yumi_o       one-hot (or zero) accept, combinational
//   out_v_o          registered packet valid towards the endpoint
//   out_packet_o     registered packet
//   out_ready_i      endpoint ready; transfer on out_v_o & out_ready_i
//   credit_return_i  one pulse per returned response
//   fence_i          level; blocks grants until all credits are back
//   grant_id_o       requester index of the held packet
//   credits_o        credits currently available
//   idle_o           nothing held and all credits available
module bp_mc_out_arbiter #(
  parameter int num_req_p      = 2,
  parameter int packet_width_p = 128,
  parameter int max_credits_p  = 16,
  localparam int credit_width_lp = $clog2(max_credits_p+1),
  localparam int id_width_lp     = $clog2(num_req_p)
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_req_p-1:0]                req_v_i,
  input  logic [num_req_p*packet_width_p-1:0] req_packet_i,
  output logic [num_req_p-1:0]                req_yumi_o,
  output logic                                out_v_o,
  output logic [packet_width_p-1:0]           out_packet_o,
  input  logic                                out_ready_i,
  input  logic                                credit_return_i,
  input  logic                                fence_i,
  output logic [id_width_lp-1:0]              grant_id_o,
  output logic [credit_width_lp-1:0]          credits_o,
  output logic                                idle_o
);

  localparam int sum_width_lp = id_width_lp + 1;
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_credits_p);
  localparam logic [credit_width_lp-1:0] one_credit_lp  = credit_width_lp'(1);
  localparam logic [id_width_lp-1:0]     last_id_lp     = id_width_lp'(num_req_p - 1);
  localparam logic [sum_width_lp-1:0]    num_req_lp     = sum_width_lp'(num_req_p);

  logic                       r_out_v;
  logic [packet_width_p-1:0]  r_packet;
  logic [id_width_lp-1:0]     r_grant_id;
  logic [credit_width_lp-1:0] r_credits;
  logic [id_width_lp-1:0]     r_ptr;

  logic                       w_slot_free;
  logic                       w_full;
  logic                       w_can_grant;
  logic                       w_found;
  logic [id_width_lp-1:0]     w_winner;
  logic                       w_grant;
  logic [num_req_p-1:0]       w_yumi;
  logic [packet_width_p-1:0]  w_win_packet;
  logic [id_width_lp-1:0]     w_ptr_next;
  logic [credit_width_lp-1:0] w_credits_next;

  assign w_slot_free = !r_out_v | out_ready_i;
  assign w_full      = (r_credits == max_credits_lp);
  // A fence only blocks while something is still outstanding; once credits
  // are back at max the grant goes out in that same cycle.
  assign w_can_grant = w_slot_free & (r_credits != '0) & !(fence_i & !w_full);

  // Round-robin search starting at the pointer, wrapping modulo num_req_p.
  always_comb begin : arb
    logic [sum_width_lp-1:0] v_idx;
    w_found  = 1'b0;
    w_winner = '0;
    v_idx    = '0;
    for (int k = 0; k < num_req_p; k++) begin
      v_idx = {1'b0, r_ptr} + sum_width_lp'(k);
      if (v_idx >= num_req_lp) v_idx = v_idx - num_req_lp;
      if (!w_found && req_v_i[v_idx[id_width_lp-1:0]]) begin
        w_found  = 1'b1;
        w_winner = v_idx[id_width_lp-1:0];
      end
    end
  end

  // Yumi is held low throughout reset, independent of register state.
  assign w_grant = w_can_grant & w_found & reset_n_i;

  always_comb begin
    w_yumi = '0;
    if (w_grant) w_yumi[w_winner] = 1'b1;
  end

  assign w_win_packet = req_packet_i[w_winner*packet_width_p +: packet_width_p];
  assign w_ptr_next   = (w_winner == last_id_lp) ? '0 : w_winner + id_width_lp'(1);

  // Credits are consumed at grant. A return at max with no grant is an
  // endpoint protocol error; the count saturates instead of wrapping.
  always_comb begin
    w_credits_next = r_credits;
    case ({w_grant, credit_return_i})
      2'b10:   w_credits_next = r_credits - one_credit_lp;
      2'b01:   w_credits_next = w_full ? r_credits : r_credits + one_credit_lp;
      default: w_credits_next = r_credits;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_out_v    <= 1'b0;
      r_packet   <= '0;
      r_grant_id <= '0;
      r_credits  <= max_credits_lp;
      r_ptr      <= '0;
    end else begin
      r_credits <= w_credits_next;
      if (w_grant) begin
        r_out_v    <= 1'b1;
        r_packet   <= w_win_packet;
        r_grant_id <= w_winner;
        r_ptr      <= w_ptr_next;
      end else if (out_ready_i) begin
        r_out_v <= 1'b0;
      end
    end
  end

  assign req_yumi_o   = w_yumi;
  assign out_v_o      = r_out_v;
  assign out_packet_o = r_packet;
  assign grant_id_o   = r_grant_id;
  assign credits_o    = r_credits;
  assign idle_o       = !r_out_v & w_full;

  a_credit_overflow : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(credit_return_i && !w_grant && w_full))
    else $error("credit overflow");

  // Requesters must hold valid and packet stable until they are yumi'd.
  for (genvar i = 0; i < num_req_p; i++) begin : g_req_chk
    a_req_hold : assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (req_v_i[i] && !req_yumi_o[i]) |=>
        (req_v_i[i] && $stable(req_packet_i[i*packet_width_p +: packet_width_p])))
      else $error("requester %0d dropped valid or changed packet before yumi", i);
  end

endmodule

// File: tb/tb_bp_mc_out_arbiter.sv
// Directed bench for bp_mc_out_arbiter with a scoreboard of expected
// output packets and a monitor that checks every endpoint transfer.
module tb_bp_mc_out_arbiter;

  localparam int NR = 2;
  localparam int PW = 128;
  localparam int MC = 16;
  localparam int CW = $clog2(MC+1);

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic [NR-1:0]    req_v_i;
  logic [NR*PW-1:0] req_packet_i;
  logic [NR-1:0]    req_yumi_o;
  logic             out_v_o;
  logic [PW-1:0]    out_packet_o;
  logic             out_ready_i;
  logic             credit_return_i;
  logic             fence_i;
  logic             grant_id_o;
  logic [CW-1:0]    credits_o;
  logic             idle_o;

  bp_mc_out_arbiter #(.num_req_p(NR), .packet_width_p(PW), .max_credits_p(MC)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .req_v_i(req_v_i), .req_packet_i(req_packet_i),
    .req_yumi_o(req_yumi_o), .out_v_o(out_v_o), .out_packet_o(out_packet_o),
    .out_ready_i(out_ready_i), .credit_return_i(credit_return_i), .fence_i(fence_i),
    .grant_id_o(grant_id_o), .credits_o(credits_o), .idle_o(idle_o));

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          id;
    logic [PW-1:0] pkt;
  } exp_t;

  exp_t          exp_q[$];
  logic [PW-1:0] src0_q[$];
  logic [PW-1:0] src1_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [PW-1:0] mkp(int tag);
    return {32'hC0DE_0000 + 32'(tag), ~32'(tag), 32'(tag) * 32'd3, 32'(tag)};
  endfunction

  task automatic expect_out(logic id, int tag);
    exp_t e;
    e.id  = id;
    e.pkt = mkp(tag);
    exp_q.push_back(e);
  endtask

  task automatic load(int r, int tag);
    if (r == 0) src0_q.push_back(mkp(tag));
    else        src1_q.push_back(mkp(tag));
  endtask

  task automatic refresh();
    req_v_i[0]          = (src0_q.size() != 0);
    req_v_i[1]          = (src1_q.size() != 0);
    req_packet_i[PW-1:0]    = (src0_q.size() != 0) ? src0_q[0] : '0;
    req_packet_i[2*PW-1:PW] = (src1_q.size() != 0) ? src1_q[0] : '0;
  endtask

  task automatic set_in(logic rdy, logic ret, logic fen);
    out_ready_i     = rdy;
    credit_return_i = ret;
    fence_i         = fen;
    #1;
  endtask

  // Advance one clock: requesters consume what was yumi'd, then return
  // positioned 1 time unit after the following falling edge.
  task automatic cyc();
    logic [1:0] y;
    y = req_yumi_o;
    @(posedge clk_i); #1;
    if (y[0] && src0_q.size() != 0) void'(src0_q.pop_front());
    if (y[1] && src1_q.size() != 0) void'(src1_q.pop_front());
    refresh();
    @(negedge clk_i); #1;
  endtask

  task automatic ret_credits(int n);
    set_in(1'b1, 1'b1, 1'b0);
    repeat (n) cyc();
    set_in(1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: inputs are driven just after the falling edge, so sampling
  // 3 units later sees the values the next rising edge will act on.
  always begin
    @(negedge clk_i); #3;
    if (reset_n_i && out_v_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_transfer: got packet %0h id %0d, expected none", out_packet_o, grant_id_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_packet", out_packet_o, e.pkt);
        check("out_grant_id", PW'(grant_id_o), PW'(e.id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ey [4];
    ey = '{2'b10, 2'b01, 2'b10, 2'b01};

    reset_n_i = 1'b0; req_v_i = '0; req_packet_i = '0;
    out_ready_i = 1'b0; credit_return_i = 1'b0; fence_i = 1'b0;
    @(negedge clk_i); #1;
    check("rst_out_v", PW'(out_v_o), 0);
    check("rst_packet", out_packet_o, 0);
    check("rst_grant_id", PW'(grant_id_o), 0);
    check("rst_credits", PW'(credits_o), 16);
    check("rst_idle", PW'(idle_o), 1);
    check("rst_yumi", PW'(req_yumi_o), 0);
    reset_n_i = 1'b1;
    cyc();

    // Single requester, three back-to-back packets, no returns.
    for (int k = 0; k < 3; k++) begin load(0, 100 + k); expect_out(1'b0, 100 + k); end
    refresh();
    set_in(1'b1, 1'b0, 1'b0);
    check("t1_yumi0", PW'(req_yumi_o), 2'b01); cyc();
    check("t1_yumi1", PW'(req_yumi_o), 2'b01);
    check("t1_outv1", PW'(out_v_o), 1);
    check("t1_gid1", PW'(grant_id_o), 0); cyc();
    check("t1_yumi2", PW'(req_yumi_o), 2'b01);
    check("t1_outv2", PW'(out_v_o), 1); cyc();
    check("t1_yumi_done", PW'(req_yumi_o), 0);
    check("t1_outv3", PW'(out_v_o), 1);
    check("t1_credits", PW'(credits_o), 13); cyc();
    check("t1_outv_drained", PW'(out_v_o), 0);
    check("t1_idle", PW'(idle_o), 0);
    ret_credits(3);
    check("t1_credits_back", PW'(credits_o), 16);
    check("t1_idle_back", PW'(idle_o), 1);

    // Both requesters valid; pointer is 1 after the last grant to 0.
    load(0, 200); load(0, 201); load(1, 300); load(1, 301);
    expect_out(1'b1, 300); expect_out(1'b0, 200);
    expect_out(1'b1, 301); expect_out(1'b0, 201);
    refresh(); #1;
    for (int k = 0; k < 4; k++) begin
      check("t2_yumi", PW'(req_yumi_o), PW'(ey[k]));
      cyc();
    end
    check("t2_yumi_done", PW'(req_yumi_o), 0);
    check("t2_credits", PW'(credits_o), 12);
    cyc();
    ret_credits(4);
    check("t2_credits_back", PW'(credits_o), 16);

    // Backpressure for five cycles, then grant in the cycle ready rises.
    load(0, 500); load(0, 501);
    expect_out(1'b0, 500); expect_out(1'b0, 501);
    refresh();
    set_in(1'b0, 1'b0, 1'b0);
    check("t3_yumi_first", PW'(req_yumi_o), 2'b01); cyc();
    check("t3_credits_stall", PW'(credits_o), 15);
    for (int k = 0; k < 5; k++) begin
      check("t3_stall_outv", PW'(out_v_o), 1);
      check("t3_stall_packet", out_packet_o, mkp(500));
      check("t3_stall_yumi", PW'(req_yumi_o), 0);
      cyc();
    end
    set_in(1'b1, 1'b0, 1'b0);
    check("t3_yumi_on_ready", PW'(req_yumi_o), 2'b01); cyc();
    check("t3_second_packet", out_packet_o, mkp(501)); cyc();
    check("t3_outv_drained", PW'(out_v_o), 0);
    check("t3_credits", PW'(credits_o), 14);
    ret_credits(2);

    // Credit exhaustion: 16 grants, stall at zero, one return -> one grant.
    for (int k = 0; k < 17; k++) begin load(1, 400 + k); expect_out(1'b1, 400 + k); end
    refresh(); #1;
    for (int k = 0; k < 16; k++) begin
      check("t4_yumi", PW'(req_yumi_o), 2'b10);
      cyc();
    end
    check("t4_credits_zero", PW'(credits_o), 0);
    check("t4_yumi_zero_a", PW'(req_yumi_o), 0); cyc();
    check("t4_yumi_zero_b", PW'(req_yumi_o), 0);
    set_in(1'b1, 1'b1, 1'b0);
    check("t4_yumi_ret_cycle", PW'(req_yumi_o), 0); cyc();
    set_in(1'b1, 1'b0, 1'b0);
    check("t4_credits_one", PW'(credits_o), 1);
    check("t4_yumi_after_ret", PW'(req_yumi_o), 2'b10); cyc();
    check("t4_credits_zero_again", PW'(credits_o), 0);
    check("t4_yumi_zero_again", PW'(req_yumi_o), 0);
    ret_credits(16);
    check("t4_credits_back", PW'(credits_o), 16);

    // Fence with four outstanding; grant fires the cycle credits reach max.
    for (int k = 0; k < 4; k++) begin load(0, 700 + k); expect_out(1'b0, 700 + k); end
    refresh(); #1;
    for (int k = 0; k < 4; k++) begin
      check("t5_yumi", PW'(req_yumi_o), 2'b01);
      cyc();
    end
    check("t5_credits", PW'(credits_o), 12);
    cyc();
    load(1, 800); expect_out(1'b1, 800);
    refresh();
    set_in(1'b1, 1'b0, 1'b1);
    check("t5_fence_block", PW'(req_yumi_o), 0);
    set_in(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t5_fence_block_ret", PW'(req_yumi_o), 0);
    end
    check("t5_credits_15", PW'(credits_o), 15);
    cyc();
    set_in(1'b1, 1'b0, 1'b1);
    check("t5_credits_full", PW'(credits_o), 16);
    check("t5_fence_release_yumi", PW'(req_yumi_o), 2'b10); cyc();
    check("t5_fence_grant_id", PW'(grant_id_o), 1);
    check("t5_credits_after", PW'(credits_o), 15);
    ret_credits(1);

    // Fence while idle has no effect.
    load(0, 900); expect_out(1'b0, 900);
    refresh();
    set_in(1'b1, 1'b0, 1'b1);
    check("t5b_idle_fence_yumi", PW'(req_yumi_o), 2'b01); cyc();
    check("t5b_credits", PW'(credits_o), 15);
    ret_credits(1);
    check("t5b_credits_back", PW'(credits_o), 16);

    // Simultaneous grant and return at five credits.
    for (int k = 0; k < 12; k++) begin load(0, 1000 + k); expect_out(1'b0, 1000 + k); end
    refresh(); #1;
    repeat (11) cyc();
    check("t6_credits5", PW'(credits_o), 5);
    check("t6_yumi", PW'(req_yumi_o), 2'b01);
    set_in(1'b1, 1'b1, 1'b0);
    cyc();
    set_in(1'b1, 1'b0, 1'b0);
    check("t6_credits_hold", PW'(credits_o), 5);
    ret_credits(11);
    check("t6_credits_back", PW'(credits_o), 16);

    // Asynchronous reset in the middle of a stall.
    load(1, 1100);
    refresh();
    set_in(1'b0, 1'b0, 1'b0);
    check("t7_yumi", PW'(req_yumi_o), 2'b10); cyc();
    load(1, 1101);
    refresh(); #1;
    check("t7_stall_yumi", PW'(req_yumi_o), 0);
    check("t7_stall_credits", PW'(credits_o), 15);
    cyc();
    reset_n_i = 1'b0; #1;
    check("t7_rst_outv", PW'(out_v_o), 0);
    check("t7_rst_credits", PW'(credits_o), 16);
    check("t7_rst_idle", PW'(idle_o), 1);
    check("t7_rst_yumi", PW'(req_yumi_o), 0);
    cyc();
    reset_n_i = 1'b1;
    expect_out(1'b1, 1101);
    set_in(1'b1, 1'b0, 1'b0);
    check("t7_post_rst_yumi", PW'(req_yumi_o), 2'b10); cyc();
    check("t7_post_rst_gid", PW'(grant_id_o), 1);
    check("t7_post_rst_credits", PW'(credits_o), 15);
    cyc();
    ret_credits(1);
    check("t7_final_idle", PW'(idle_o), 1);

    repeat (3) cyc();
    check("scoreboard_empty", PW'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
